// File: rtl/led_frame_sequencer.sv
// Frame sequencer for a serial RGB LED chain: streams GRB pixels MSB first to a
// bit generator, prefetching the next pixel, then issues the RET (latch) symbols.
module led_frame_sequencer #(
    parameter int RET_SYMBOLS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  numLeds,
    input  logic [23:0] pixData,
    input  logic        genDone,
    output logic [7:0]  pixAddr,
    output logic [1:0]  genMode,
    output logic        doGen,
    output logic        busy,
    output logic        frameDone
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, RET} state_t;

    localparam logic [7:0] RET_LAST = 8'(RET_SYMBOLS - 1);

    state_t      state_q;
    logic [7:0]  numLeds_q;
    logic [22:0] shift_q;     // bits still to send after the one on genMode
    logic [23:0] next_q;
    logic [4:0]  bitCnt_q;
    logic [7:0]  pixCnt_q;
    logic [7:0]  retCnt_q;
    logic [7:0]  pixAddr_q;
    logic [1:0]  genMode_q;
    logic        doGen_q;
    logic        busy_q;
    logic        frameDone_q;

    assign pixAddr   = pixAddr_q;
    assign genMode   = genMode_q;
    assign doGen     = doGen_q;
    assign busy      = busy_q;
    assign frameDone = frameDone_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            numLeds_q   <= '0;
            shift_q     <= '0;
            next_q      <= '0;
            bitCnt_q    <= '0;
            pixCnt_q    <= '0;
            retCnt_q    <= '0;
            pixAddr_q   <= '0;
            genMode_q   <= 2'b00;
            doGen_q     <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The frameDone cycle is spent dropping busy, so a held start
                    // re-triggers no earlier than the following cycle.
                    if (frameDone_q) begin
                        frameDone_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (start && numLeds != 8'd0) begin
                        numLeds_q <= numLeds;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q   <= pixData[22:0];
                    genMode_q <= {1'b1, pixData[23]};
                    pixAddr_q <= 8'd1;
                    bitCnt_q  <= '0;
                    pixCnt_q  <= '0;
                    doGen_q   <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    // The RAM output settles long before the 24th bit ends, so
                    // sampling it every cycle keeps the next pixel ready.
                    next_q <= pixData;
                    if (genDone) begin
                        if (bitCnt_q != 5'd23) begin
                            genMode_q <= {1'b1, shift_q[22]};
                            shift_q   <= {shift_q[21:0], 1'b0};
                            bitCnt_q  <= bitCnt_q + 5'd1;
                        end else if (pixCnt_q != numLeds_q - 8'd1) begin
                            genMode_q <= {1'b1, next_q[23]};
                            shift_q   <= next_q[22:0];
                            bitCnt_q  <= '0;
                            pixCnt_q  <= pixCnt_q + 8'd1;
                            pixAddr_q <= pixAddr_q + 8'd1;
                        end else begin
                            genMode_q <= 2'b00;
                            retCnt_q  <= '0;
                            state_q   <= RET;
                        end
                    end
                end
                RET: begin
                    if (genDone) begin
                        if (retCnt_q == RET_LAST) begin
                            doGen_q     <= 1'b0;
                            genMode_q   <= 2'b00;
                            frameDone_q <= 1'b1;
                            pixAddr_q   <= '0;
                            state_q     <= IDLE;
                        end else begin
                            retCnt_q <= retCnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench: stimulus queues the expected {genMode, pixAddr} per symbol,
// a monitor pops one entry on every genDone accepted by the sequencer.
module tb_led_frame_sequencer;

    localparam int RET_A = 40;

    logic        clk = 1'b0;
    logic        reset, start, genDone;
    logic [7:0]  numLeds;
    logic [23:0] pixData;
    logic [7:0]  pixAddr;
    logic [1:0]  genMode;
    logic        doGen, busy, frameDone;

    logic        start_b, genDone_b;
    logic [7:0]  numLeds_b;
    logic [23:0] pixData_b;
    logic [7:0]  pixAddr_b;
    logic [1:0]  genMode_b;
    logic        doGen_b, busy_b, frameDone_b;

    logic [23:0] mem [0:255];
    logic [23:0] pipe_a, pipe_b;
    logic [9:0]  exp_q[$];
    logic [9:0]  exp_b[$];
    logic [9:0]  mon_e, mon_eb;
    int          period, gc_a;
    logic        inj;
    int          tests = 0, fails = 0;
    int          pulses = 0, fd_cnt = 0, pulses_b = 0, fd_b = 0, max_addr_b = 0;

    always #5 clk = ~clk;

    led_frame_sequencer #(.RET_SYMBOLS(RET_A)) u_dut (
        .clk(clk), .reset(reset), .start(start), .numLeds(numLeds), .pixData(pixData),
        .genDone(genDone), .pixAddr(pixAddr), .genMode(genMode), .doGen(doGen),
        .busy(busy), .frameDone(frameDone)
    );

    led_frame_sequencer #(.RET_SYMBOLS(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .numLeds(numLeds_b), .pixData(pixData_b),
        .genDone(genDone_b), .pixAddr(pixAddr_b), .genMode(genMode_b), .doGen(doGen_b),
        .busy(busy_b), .frameDone(frameDone_b)
    );

    function automatic logic [23:0] pix_b(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Synchronous pixel RAMs: data for the address seen in one cycle appears the next.
    initial begin
        pipe_a = '0; pixData = '0; pipe_b = '0; pixData_b = '0;
        forever begin
            @(posedge clk); #1;
            pixData   = pipe_a;
            pipe_a    = mem[pixAddr];
            pixData_b = pipe_b;
            pipe_b    = pix_b(pixAddr_b);
        end
    end

    // Bit generator models.
    initial begin
        genDone = 1'b0; genDone_b = 1'b0; gc_a = 0;
        forever begin
            @(posedge clk); #1;
            genDone_b = doGen_b;
            if (doGen) begin
                if (gc_a >= period - 1) begin
                    genDone = 1'b1; gc_a = 0;
                end else begin
                    genDone = 1'b0; gc_a++;
                end
            end else begin
                genDone = inj; gc_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (frameDone) fd_cnt++;
        if (genDone && doGen) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected_symbol", 32'(genMode), 32'hFFFF_FFFF);
            else begin
                mon_e = exp_q.pop_front();
                chk("genMode", 32'(genMode), 32'(mon_e[9:8]));
                chk("pixAddr", 32'(pixAddr), 32'(mon_e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (frameDone_b) fd_b++;
        if (doGen_b && int'(pixAddr_b) > max_addr_b) max_addr_b = int'(pixAddr_b);
        if (genDone_b && doGen_b) begin
            pulses_b++;
            if (exp_b.size() == 0) chk("b_unexpected_symbol", 32'(genMode_b), 32'hFFFF_FFFF);
            else begin
                mon_eb = exp_b.pop_front();
                chk("b_genMode", 32'(genMode_b), 32'(mon_eb[9:8]));
                chk("b_pixAddr", 32'(pixAddr_b), 32'(mon_eb[7:0]));
            end
        end
    end

    task automatic push_frame(input int n);
        for (int k = 0; k < n; k++)
            for (int b = 23; b >= 0; b--)
                exp_q.push_back({1'b1, mem[k][b], 8'(k + 1)});
        for (int r = 0; r < RET_A; r++) exp_q.push_back({2'b00, 8'(n)});
    endtask

    task automatic start_frame(input int n);
        @(negedge clk);
        numLeds = 8'(n); start = 1'b1; inj = 1'b1;
        @(negedge clk);
        start = 1'b0; inj = 1'b0; numLeds = 8'd7;
        chk("load_doGen", 32'(doGen), 32'd0);
        chk("load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("send_doGen", 32'(doGen), 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget, input int restart_at);
        int c = 0;
        bit rs = 1'b0;
        while (frameDone !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
            if (restart_at >= 0) begin
                if (!rs && pulses >= restart_at) begin start = 1'b1; rs = 1'b1; end
                else start = 1'b0;
            end
        end
        if (frameDone !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({name, "_fd_busy"}, 32'(busy), 32'd1);
            chk({name, "_fd_doGen"}, 32'(doGen), 32'd0);
            chk({name, "_fd_genMode"}, 32'(genMode), 32'd0);
            chk({name, "_fd_pixAddr"}, 32'(pixAddr), 32'd0);
            @(negedge clk);
            chk({name, "_post_busy"}, 32'(busy), 32'd0);
            chk({name, "_post_fd"}, 32'(frameDone), 32'd0);
        end
    endtask

    task automatic do_frame(input string name, input int n, input int p, input int budget,
                            input int restart_at);
        int f0;
        period = p; pulses = 0; f0 = fd_cnt;
        push_frame(n);
        repeat (3) @(negedge clk);
        start_frame(n);
        wait_done(name, budget, restart_at);
        chk({name, "_pulses"}, 32'(pulses), 32'(24 * n + RET_A));
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_frameDones"}, 32'(fd_cnt - f0), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, f0, bad;
        reset = 1'b0; start = 1'b0; numLeds = '0; inj = 1'b0; period = 1;
        start_b = 1'b0; numLeds_b = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_pixAddr", 32'(pixAddr), 32'd0);
        chk("rst_genMode", 32'(genMode), 32'd0);
        chk("rst_doGen", 32'(doGen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frameDone", 32'(frameDone), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        reset = 1'b1;

        // Single LED A5_0F_C3, slow generator.
        mem[0] = 24'hA50FC3;
        do_frame("one_led", 1, 125, 9000, -1);

        // Three LEDs back to back.
        mem[0] = 24'hFFFFFF; mem[1] = 24'h000000; mem[2] = 24'h800001;
        do_frame("three_led", 3, 3, 1000, -1);

        // Zero LEDs and stray genDone pulses in IDLE.
        f0 = fd_cnt; bad = 0;
        @(negedge clk); numLeds = 8'd0; start = 1'b1; inj = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy || doGen) bad++;
        end
        start = 1'b0; inj = 1'b0;
        chk("zero_leds_active_cycles", 32'(bad), 32'd0);
        chk("zero_leds_frameDone", 32'(fd_cnt - f0), 32'd0);

        // Restart during SEND is dropped.
        mem[0] = 24'h3C5A96; mem[1] = 24'hC3A569;
        do_frame("restart", 2, 3, 1000, 10);
        f0 = fd_cnt;
        repeat (40) @(negedge clk);
        chk("restart_no_second", 32'(fd_cnt - f0), 32'd0);
        chk("restart_idle_busy", 32'(busy), 32'd0);

        // Start held across frameDone: one idle cycle, then a new frame.
        mem[0] = 24'h0F0F0F;
        period = 2; pulses = 0; f0 = fd_cnt;
        push_frame(1); push_frame(1);
        @(negedge clk); numLeds = 8'd1; start = 1'b1;
        wait_done("held1", 500, -1);
        @(negedge clk);
        chk("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("held2", 500, -1);
        chk("held_pulses", 32'(pulses), 32'(2 * (24 + RET_A)));
        chk("held_frameDones", 32'(fd_cnt - f0), 32'd2);
        chk("held_queue_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset after 30 data bits.
        mem[0] = 24'h123456; mem[1] = 24'hFEDCBA;
        period = 2; pulses = 0; f0 = fd_cnt;
        push_frame(2);
        repeat (3) @(negedge clk);
        start_frame(2);
        c = 0;
        while (pulses < 30 && c < 500) begin @(negedge clk); c++; end
        chk("rst_mid_reached", 32'(pulses >= 30), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_doGen", 32'(doGen), 32'd0);
        chk("rst_mid_genMode", 32'(genMode), 32'd0);
        chk("rst_mid_pixAddr", 32'(pixAddr), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_frameDone", 32'(frameDone), 32'd0);
        exp_q.delete();
        @(negedge clk); reset = 1'b1;
        repeat (50) @(negedge clk);
        chk("rst_mid_no_frameDone", 32'(fd_cnt - f0), 32'd0);
        chk("rst_mid_idle_busy", 32'(busy), 32'd0);
        do_frame("after_reset", 2, 2, 1000, -1);

        // 255 LEDs, one RET symbol, genDone every cycle.
        for (int k = 0; k < 255; k++)
            for (int b = 23; b >= 0; b--)
                exp_b.push_back({1'b1, pix_b(8'(k))[b], 8'(k + 1)});
        exp_b.push_back({2'b00, 8'd255});
        @(negedge clk); numLeds_b = 8'd255; start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; numLeds_b = 8'd0;
        c = 0;
        while (frameDone_b !== 1'b1 && c < 7000) begin @(negedge clk); c++; end
        chk("b_frameDone_seen", 32'(frameDone_b), 32'd1);
        @(negedge clk);
        chk("b_pulses", 32'(pulses_b), 32'd6121);
        chk("b_max_addr", 32'(max_addr_b), 32'd255);
        chk("b_queue_left", 32'(exp_b.size()), 32'd0);
        chk("b_frameDones", 32'(fd_b), 32'd1);
        chk("b_post_busy", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
